// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the processor load/store port. It replaces the
// zero-latency combinational data memory on multi-cycle core variants. One
// request is accepted at a time over a valid/ready handshake, a programmable
// number of wait states is inserted, and then the access is performed against
// the internal word array and the result is offered on a valid/ready
// response channel.
//
// Accesses:
//   word (lw/sw)  full 32-bit word at word index addr[ADDR_W-1:2]
//   byte (lb/sb)  big-endian lane: addr[1:0]=0 -> [31:24] ... 3 -> [7:0]
//                 lb sign-extends the lane, sb leaves other lanes unchanged
//
// Configuration macro:
//   DMEM_ERR_EN   when defined, misaligned word accesses and word indices
//                 >= DEPTH_WORDS complete with resp_err=1, rdata=0 and no
//                 array write (same latency). When undefined, resp_err is 0,
//                 word accesses ignore addr[1:0] and indices wrap modulo
//                 DEPTH_WORDS.
//
// Parameters:
//   DEPTH_WORDS   array size in 32-bit words (power of two)
//   ADDR_W        byte-address width
//   WAIT_CYCLES   wait states between accept and access (0..15)
//
// Ports:
//   CLK           clock, all state changes on the rising edge
//   RST           synchronous active-high reset (aborts any transaction)
//   req_valid     request present
//   req_ready     responder can accept (high only in IDLE)
//   req_write     1 = store, 0 = load
//   req_byte      1 = byte access, 0 = word access
//   req_addr      byte address
//   req_wdata     store data (sb uses [7:0])
//   resp_valid    response present
//   resp_ready    CPU accepts the response
//   resp_rdata    load data, 0 for stores and errors
//   resp_err      access rejected
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;

  // Request fields captured at accept time.
  logic              lat_write;
  logic              lat_byte;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  // Fields of the access being performed this cycle. In IDLE they come
  // straight from the request port so that WAIT_CYCLES=0 can access on the
  // accept edge; otherwise they come from the captured copy.
  logic              acc_write;
  logic              acc_byte;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic              acc_fire;
  logic              accept;

  logic [31:0]       rd_word;
  logic [7:0]        rd_lane;
  logic [31:0]       acc_rdata;
  logic [31:0]       wr_word;
  logic              mem_we;

  logic [31:0]       mem [DEPTH_WORDS];

  assign accept = (state == S_IDLE) && req_valid && req_ready;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_write = lat_write;
    acc_byte  = lat_byte;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_byte  = req_byte;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  // The access happens on the accept edge when there are no wait states,
  // otherwise on the edge that ends the last WAIT cycle.
  always_comb begin
    acc_fire = 1'b0;
    if (WAIT_CYCLES == 0) begin
      acc_fire = accept;
    end else begin
      acc_fire = (state == S_WAIT) && (cnt == 4'd0);
    end
  end

  // Only the low IDX_W bits of the word index address the array; in the
  // default build this is what makes out-of-range indices wrap.
  assign acc_idx = acc_addr[IDX_W+1:2];

`ifdef DMEM_ERR_EN
  always_comb begin
    acc_err = 1'b0;
    if (!acc_byte && (acc_addr[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end
    if ({1'b0, acc_addr[ADDR_W-1:2]} >= (ADDR_W-1)'(DEPTH_WORDS)) begin
      acc_err = 1'b1;
    end
  end
`else
  assign acc_err = 1'b0;
`endif

  // Upper address bits are intentionally ignored in the default build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr;

  // Read side: select the big-endian lane and shape the load result.
  assign rd_word = mem[acc_idx];

  always_comb begin
    rd_lane = rd_word[31:24];
    case (acc_addr[1:0])
      2'd0: rd_lane = rd_word[31:24];
      2'd1: rd_lane = rd_word[23:16];
      2'd2: rd_lane = rd_word[15:8];
      2'd3: rd_lane = rd_word[7:0];
      default: rd_lane = rd_word[31:24];
    endcase
  end

  always_comb begin
    acc_rdata = 32'd0;
    if (!acc_write && !acc_err) begin
      acc_rdata = acc_byte ? {{24{rd_lane[7]}}, rd_lane} : rd_word;
    end
  end

  // Write side: byte stores merge the new lane into the current word.
  always_comb begin
    wr_word = acc_wdata;
    if (acc_byte) begin
      wr_word = rd_word;
      case (acc_addr[1:0])
        2'd0: wr_word[31:24] = acc_wdata[7:0];
        2'd1: wr_word[23:16] = acc_wdata[7:0];
        2'd2: wr_word[15:8]  = acc_wdata[7:0];
        2'd3: wr_word[7:0]   = acc_wdata[7:0];
        default: wr_word = rd_word;
      endcase
    end
  end

  // Reset suppresses the commit so an aborted store never reaches the array.
  assign mem_we = acc_fire && acc_write && !acc_err && !RST;

  // NOTE: the storage array has no reset; its contents survive RST and
  // clearing it would turn the RAM into a wide register file.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[acc_idx] <= wr_word;
    end
  end

  // Request capture is plain datapath; it only needs to be valid after an
  // accept, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lat_write <= req_write;
      lat_byte  <= req_byte;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= acc_rdata;
              resp_err   <= acc_err;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end

        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= acc_rdata;
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_RESP: begin
          // rdata/err stay put until the CPU takes them; req_ready only
          // rises after the handshake edge, so no accept in that cycle.
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 18;
  localparam int WC    = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic          req_byte = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] m [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain arithmetic on a word array.
  task automatic model(input bit wr, input bit byt, input int addr,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int idx, lane, sh;
    logic [31:0] b;
    idx  = addr / 4;
    lane = addr % 4;
    sh   = 8 * (3 - lane);
    err  = 1'b0;
    rd   = 32'd0;
`ifdef DMEM_ERR_EN
    if ((!byt && lane != 0) || idx >= DEPTH) err = 1'b1;
`endif
    idx = idx % DEPTH;
    if (!err) begin
      if (wr) begin
        if (byt) m[idx] = (m[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        else     m[idx] = wd;
      end else if (byt) begin
        b  = (m[idx] >> sh) & 32'hFF;
        rd = (b >= 128) ? b + 32'hFFFFFF00 : b;
      end else begin
        rd = m[idx];
      end
    end
  endtask

  // Drives one request, returns what the DUT responded and the number of
  // sampled cycles from accept until resp_valid was seen.
  task automatic do_req(input bit wr, input bit byt, input int addr,
                        input logic [31:0] wd, input int delay,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge CLK);
    req_valid = 1'b1; req_write = wr; req_byte = byt;
    req_addr = AW'(addr); req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 60) begin @(negedge CLK); lat++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h: no resp_valid within %0d cycles", addr, lat);
      rd = 'x; er = 'x;
      return;
    end
    repeat (delay) @(negedge CLK);
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
  endtask

  task automatic test_word;
    logic [31:0] rd, erd; logic er, eer; int lat;
    model(1, 0, 'h10, 32'hDEADBEEF, erd, eer);
    do_req(1, 0, 'h10, 32'hDEADBEEF, 0, rd, er, lat);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL sw_latency got=%0d exp=%0d", lat, WC + 1); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL post_handshake got v=%b d=%h r=%b exp 0/0/1", resp_valid, resp_rdata, req_ready);
    end
    model(0, 0, 'h10, 0, erd, eer);
    do_req(0, 0, 'h10, 0, 1, rd, er, lat);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL lw_latency got=%0d exp=%0d", lat, WC + 1); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL lw_data got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_byte;
    logic [31:0] rd, erd; logic er, eer; int lat;
    model(1, 1, 'h11, 32'h80, erd, eer);
    do_req(1, 1, 'h11, 32'h80, 0, rd, er, lat);
    model(0, 1, 'h11, 0, erd, eer);
    do_req(0, 1, 'h11, 0, 0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb_sext got=%h/%b exp=ffffff80/0", rd, er); end
    model(0, 0, 'h10, 0, erd, eer);
    do_req(0, 0, 'h10, 0, 0, rd, er, lat);
    checks++; if (rd !== 32'hDE80BEEF) begin errors++; $display("FAIL sb_merge got=%h exp=de80beef", rd); end
  endtask

  task automatic test_stall;
    logic [31:0] rd, erd; logic er, eer; int lat, n;
    model(0, 0, 'h10, 0, erd, eer);
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = AW'('h10);
    @(posedge CLK);
    @(negedge CLK);
    // Stray store request while waiting: must be ignored.
    req_write = 1'b1; req_wdata = 32'h0;
    for (int k = 0; k < WC; k++) begin
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_req_ready cyc=%0d got=%b exp=0", k, req_ready); end
      @(negedge CLK);
    end
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge CLK); n++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== erd || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h r=%b exp 1/%h/0", k, resp_valid, resp_rdata, req_ready, erd);
      end
      @(negedge CLK);
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", resp_valid); end
    model(0, 0, 'h10, 0, erd, eer);
    do_req(0, 0, 'h10, 0, 0, rd, er, lat);
    checks++; if (rd !== 32'hDE80BEEF) begin errors++; $display("FAIL ignored_store got=%h exp=de80beef", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd, exp0; logic er, eer; int lat;
    model(1, 0, 'h0, 32'h0BADF00D, erd, eer);
    do_req(1, 0, 'h0, 32'h0BADF00D, 0, rd, er, lat);
    model(0, 0, 'h12, 0, erd, eer);
    do_req(0, 0, 'h12, 0, 0, rd, er, lat);
`ifdef DMEM_ERR_EN
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL misaligned got=%h/%b exp=0/1", rd, er); end
`else
    checks++; if (rd !== 32'hDE80BEEF || er !== 1'b0) begin errors++; $display("FAIL misaligned got=%h/%b exp=de80beef/0", rd, er); end
`endif
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL err_latency got=%0d exp=%0d", lat, WC + 1); end
    model(0, 0, 'h1000, 0, erd, eer);
    do_req(0, 0, 'h1000, 0, 0, rd, er, lat);
`ifdef DMEM_ERR_EN
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL out_of_range got=%h/%b exp=0/1", rd, er); end
    exp0 = 32'h0BADF00D;
`else
    checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL wrap got=%h/%b exp=0badf00d/0", rd, er); end
    exp0 = 32'hFFFFFFFF;
`endif
    model(1, 0, 'h1000, 32'hFFFFFFFF, erd, eer);
    do_req(1, 0, 'h1000, 32'hFFFFFFFF, 0, rd, er, lat);
    model(0, 0, 'h0, 0, erd, eer);
    do_req(0, 0, 'h0, 0, 0, rd, er, lat);
    checks++; if (rd !== exp0) begin errors++; $display("FAIL oor_store got=%h exp=%h", rd, exp0); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, erd; logic er, eer; int lat;
    model(1, 0, 'h20, 32'hA5A5A5A5, erd, eer);
    do_req(1, 0, 'h20, 32'hA5A5A5A5, 0, rd, er, lat);
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
    req_addr = AW'('h20); req_wdata = 32'h12345678;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL abort_idle cyc=%0d got v=%b r=%b exp 0/1", k, resp_valid, req_ready);
      end
      @(negedge CLK);
    end
    model(0, 0, 'h20, 0, erd, eer);
    do_req(0, 0, 'h20, 0, 0, rd, er, lat);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL abort_dropped got=%h exp=a5a5a5a5", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, wd; logic er, eer; int lat, a, w;
    bit wr, byt;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1, 0, i * 4, wd, erd, eer);
      do_req(1, 0, i * 4, wd, 0, rd, er, lat);
    end
    for (int i = 0; i < 48; i++) begin
      wr  = 1'($urandom % 2);
      byt = 1'($urandom % 2);
      w   = int'($urandom % 16) + (($urandom % 8 == 0) ? DEPTH : 0);
      a   = w * 4;
      if (byt || ($urandom % 6 == 0)) a += int'($urandom % 4);
      wd  = $urandom;
      model(wr, byt, a, wd, erd, eer);
      do_req(wr, byt, a, wd, int'($urandom % 4), rd, er, lat);
      checks++;
      if (rd !== erd || er !== eer || lat !== WC + 1) begin
        errors++;
        $display("FAIL random_%0d w=%b b=%b a=%h got=%h/%b/%0d exp=%h/%b/%0d",
                 i, wr, byt, a, rd, er, lat, erd, eer, WC + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_stall();
    test_errors();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
